// File: rtl/bram_port_arbiter.sv
// Clear-then-share sequencer for one BRAM port: sweeps the RAM to zero after reset, then round-robins requesters A/B.
// Optional BRAM_ARB_DOREG_EN targets a BRAM with its output register enabled (one extra read-latency cycle).
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_regce,
  input  logic [DATA_W-1:0] ram_do
);

  // state  | meaning
  // S_INIT | zero-fill sweep over every address, no grants
  // S_RUN  | round-robin arbitration between A and B

`ifdef BRAM_ARB_DOREG_EN
  localparam int TAG_D = 2;
  assign ram_regce = 1'b1;
`else
  localparam int TAG_D = 1;
  assign ram_regce = 1'b0;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W:0]   sweep_cnt;
  logic              last_a;
  logic [TAG_D-1:0]  tag_v;
  logic [TAG_D-1:0]  tag_id;
  logic              rd_issue;

  // init_done is high exactly while in S_RUN, so it doubles as the grant enable
  assign gnt_a = init_done & req_a & (~req_b | ~last_a);
  assign gnt_b = init_done & req_b & (~req_a | last_a);

  assign rd_issue = (gnt_a & ~we_a) | (gnt_b & ~we_b);

  assign rdata_a = ram_do;
  assign rdata_b = ram_do;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      last_a    <= 1'b0;
      tag_v     <= '0;
      tag_id    <= '0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      init_done <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_di    <= '0;
    end else begin
      // tag enters stage 0 together with the RAM command; rvalid is the registered pipeline tail
      tag_v    <= TAG_D'({tag_v, rd_issue});
      tag_id   <= TAG_D'({tag_id, gnt_b});
      rvalid_a <= tag_v[TAG_D-1] & ~tag_id[TAG_D-1];
      rvalid_b <= tag_v[TAG_D-1] & tag_id[TAG_D-1];
      case (state)
        S_INIT: begin
          if (sweep_cnt[ADDR_W]) begin
            state     <= S_RUN;
            init_done <= 1'b1;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
          end else begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= sweep_cnt[ADDR_W-1:0];
            ram_di    <= '0;
            sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
          end
        end
        S_RUN: begin
          if (gnt_a || gnt_b) begin
            ram_en   <= 1'b1;
            ram_we   <= gnt_a ? we_a : we_b;
            ram_addr <= gnt_a ? addr_a : addr_b;
            ram_di   <= gnt_a ? wdata_a : wdata_b;
            last_a   <= gnt_a;
          end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioral BRAM (output register added under BRAM_ARB_DOREG_EN).
module tb_bram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef BRAM_ARB_DOREG_EN
  localparam int LAT = 3;
  localparam logic EXP_REGCE = 1'b1;
`else
  localparam int LAT = 2;
  localparam logic EXP_REGCE = 1'b0;
`endif

  logic clk, rst_n;
  logic req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
  logic [DW-1:0] rdata_a, rdata_b;
  logic ram_en, ram_we, ram_regce;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .init_done(init_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_regce(ram_regce), .ram_do(ram_do)
  );

  // behavioral BRAM
  logic [DW-1:0] mem [16];
  logic [DW-1:0] dout;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        dout <= mem[ram_addr];
    end
  end
`ifdef BRAM_ARB_DOREG_EN
  logic [DW-1:0] do_q;
  always @(posedge clk) if (ram_regce) do_q <= dout;
  assign ram_do = do_q;
`else
  assign ram_do = dout;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic          glog[$];
  logic [DW-1:0] model_mem [16];

  // grant monitor: updates the memory model, pushes read expectations, checks the registered RAM command
  logic          pend, prev_run;
  logic          pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_di;
  rd_exp_t       e_new;
  initial begin pend = 1'b0; prev_run = 1'b0; end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      prev_run = 1'b0;
    end else begin
      if (pend) begin
        chk("cmd_en", ram_en, 1);
        chk("cmd_we", ram_we, pend_we);
        chk("cmd_addr", ram_addr, pend_addr);
        if (pend_we) chk("cmd_di", ram_di, pend_di);
      end else if (prev_run) begin
        chk("idle_en", ram_en, 0);
      end
      pend = 1'b0;
      if (gnt_a || gnt_b) begin
        chk("gnt_excl", gnt_a & gnt_b, 0);
        chk("gnt_in_init", init_done, 1);
        chk("gnt_req", gnt_a ? req_a : req_b, 1);
        pend      = 1'b1;
        pend_we   = gnt_a ? we_a : we_b;
        pend_addr = gnt_a ? addr_a : addr_b;
        pend_di   = gnt_a ? wdata_a : wdata_b;
        glog.push_back(gnt_b);
        if (pend_we) model_mem[pend_addr] = pend_di;
        else begin
          e_new.id   = gnt_b;
          e_new.data = model_mem[pend_addr];
          e_new.due  = cyc + LAT;
          sb.push_back(e_new);
        end
      end
      prev_run = init_done;
    end
  end

  // response monitor
  rd_exp_t e_got;
  always @(negedge clk) begin
    if (rvalid_a || rvalid_b) begin
      chk("rv_excl", rvalid_a & rvalid_b, 0);
      chk("rv_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_got = sb.pop_front();
        chk("rv_id", rvalid_b, e_got.id);
        chk("rdata", rvalid_b ? rdata_b : rdata_a, e_got.data);
        chk("rv_latency", cyc, e_got.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic side, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    logic got;
    got = 1'b0;
    if (side) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = side ? gnt_b : gnt_a;
    end
    chk(side ? "gnt_b_wait" : "gnt_a_wait", got, 1);
    step();
    if (side) req_b = 1'b0;
    else      req_a = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    step();
  endtask

  task automatic sweep_check();
    int idx;
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done) break;
      if (ram_en) begin
        chk("sweep_cmd", {ram_we, ram_di}, {1'b1, 8'h00});
        chk("sweep_addr", ram_addr, idx);
        idx++;
      end
    end
    chk("sweep_len", idx, 16);
    chk("init_done", init_done, 1);
    chk("post_sweep_idle_addr", ram_addr, 15);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_gnt"}, {gnt_a, gnt_b}, 0);
    chk({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_en_we"}, {ram_en, ram_we}, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_di"}, ram_di, 0);
    chk({tag, "_regce"}, ram_regce, EXP_REGCE);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (2) @(negedge clk);
    reset_outputs("rst");
    rst_n = 1'b1;

    // 1: sweep with no requests
    sweep_check();
    step();

    // 2: A writes, B reads it back
    access(1'b0, 1'b1, 4'd3, 8'h5A);
    access(1'b1, 1'b0, 4'd3, 8'h00);
    drain();

    // 3: both requesting for 6 cycles; B was granted last so A leads
    glog.delete();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd8; wdata_a = 8'hA0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd9; wdata_b = 8'hB0;
    repeat (6) @(negedge clk);
    step();
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);
    access(1'b0, 1'b0, 4'd8, 8'h00);
    access(1'b1, 1'b0, 4'd9, 8'h00);
    drain();

    // 4: writes then back-to-back reads from A
    for (int i = 0; i < 8; i++) access(1'b0, 1'b1, AW'(i), DW'(8'h10 + i));
    for (int i = 0; i < 8; i++) access(1'b0, 1'b0, AW'(i), 8'h00);
    drain();

    // 5: reset with two reads in flight, then 6: B held through the new sweep
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
    @(negedge clk);
    chk("inflight_gnt0", gnt_a, 1);
    step();
    addr_a = 4'd1;
    @(negedge clk);
    chk("inflight_gnt1", gnt_a, 1);
    #1;
    rst_n = 1'b0;
    req_a = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd3;
    repeat (3) @(negedge clk);
    reset_outputs("midrst");
    rst_n = 1'b1;
    sweep_check();
    chk("b_first_run_gnt", gnt_b, 1);
    step();
    req_b = 1'b0;
    drain();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
